xc_sha2_sigma_mcu: RTL and testbench

Multi-cycle functional unit computing the SHA-2 sigma/Sum functions for SHA-256 and SHA-512 (sigma0, sigma1, Sum0, Sum1). It sits beside the ALU in the execute stage and uses a valid/ready handshake on both input and output. It generalises the single-function SHA-256 sigma1 datapath in three ways: parametrised XLEN, an 8-op mode select, and an optional serial implementation that reuses one rotator across three cycles.

---
 rtl/xc_sha2_sigma_mcu.sv | 171 +++++++++++++++++
 tb/tb_xc_sha2_sigma_mcu.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/xc_sha2_sigma_mcu.sv
// ============================================================================
// xc_sha2_sigma_mcu : SHA-256/512 sigma/Sum unit, serial or parallel rotator
// Revision: 1.0
// ============================================================================
`default_nettype none

module xc_sha2_sigma_mcu #(
  parameter int XLEN   = 32,
  parameter int SERIAL = 1
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_trap
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic HAS_512 = (XLEN == 64);

  // Rotation/shift amounts per op, in the order the terms are accumulated.
  localparam logic [5:0] TERM_AMT [0:7][0:2] = '{
    '{6'd7,  6'd18, 6'd3 }, '{6'd17, 6'd19, 6'd10},
    '{6'd2,  6'd13, 6'd22}, '{6'd6,  6'd11, 6'd25},
    '{6'd1,  6'd8,  6'd7 }, '{6'd19, 6'd61, 6'd6 },
    '{6'd28, 6'd34, 6'd39}, '{6'd14, 6'd18, 6'd41}
  };

  // 32-bit terms come back sign-extended so their XOR is the sign-extended sum.
  function automatic logic [XLEN-1:0] sha_term(input logic [2:0] op,
                                                input logic [1:0] k,
                                                input logic [XLEN-1:0] x);
    logic [63:0] x64;
    logic [63:0] r64;
    logic [31:0] x32;
    logic [31:0] r32;
    logic [5:0]  n;
    logic        shf;
    x64 = 64'(x);
    x32 = x[31:0];
    n   = TERM_AMT[op][k];
    shf = (k == 2'd2) && !op[1];
    r64 = shf ? (x64 >> n) : ((x64 >> n) | (x64 << (7'd64 - {1'b0, n})));
    r32 = shf ? (x32 >> n) : ((x32 >> n) | (x32 << (6'd32 - n)));
    if (!op[2]) r64 = {{32{r32[31]}}, r32};
    sha_term = r64[XLEN-1:0];
  endfunction

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   rs1_q, rs1_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        out_rd_q, out_rd_d;
  logic              trap_q, trap_d;

  logic [1:0]        step;
  logic [XLEN-1:0]   step_term;
  logic [XLEN-1:0]   par_result;
  logic              illegal_in;

  assign step       = (state_q == S_T1) ? 2'd1 : (state_q == S_T2) ? 2'd2 : 2'd0;
  assign step_term  = sha_term(op_q, step, rs1_q);
  assign par_result = sha_term(in_op, 2'd0, in_rs1) ^ sha_term(in_op, 2'd1, in_rs1)
                    ^ sha_term(in_op, 2'd2, in_rs1);
  assign illegal_in = in_op[2] && !HAS_512;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rs1_d    = rs1_q;
    rd_d     = rd_q;
    acc_d    = acc_q;
    result_d = result_q;
    out_rd_d = out_rd_q;
    trap_d   = trap_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_d  = in_op;
            rs1_d = in_rs1;
            rd_d  = in_rd;
            acc_d = '0;
            if (illegal_in) begin
              state_d  = S_DONE;
              result_d = '0;
              trap_d   = 1'b1;
              out_rd_d = in_rd;
            end else if (SERIAL != 0) begin
              state_d = S_T0;
            end else begin
              state_d  = S_DONE;
              result_d = (in_rd == 5'd0) ? '0 : par_result;
              trap_d   = 1'b0;
              out_rd_d = in_rd;
            end
          end
        end
        S_T0: begin
          acc_d   = acc_q ^ step_term;
          state_d = S_T1;
        end
        S_T1: begin
          acc_d   = acc_q ^ step_term;
          state_d = S_T2;
        end
        S_T2: begin
          acc_d    = acc_q ^ step_term;
          result_d = (rd_q == 5'd0) ? '0 : (acc_q ^ step_term);
          trap_d   = 1'b0;
          out_rd_d = rd_q;
          state_d  = S_DONE;
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      rs1_q    <= '0;
      rd_q     <= '0;
      acc_q    <= '0;
      result_q <= '0;
      out_rd_q <= '0;
      trap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rs1_q    <= rs1_d;
      rd_q     <= rd_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      out_rd_q <= out_rd_d;
      trap_q   <= trap_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign out_result = result_q;
  assign out_rd     = out_rd_q;
  assign out_trap   = trap_q;

endmodule

`default_nettype wire

// File: tb/tb_xc_sha2_sigma_mcu.sv
// ============================================================================
// tb_xc_sha2_sigma_mcu : checks a 32-bit serial and a 64-bit parallel instance
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_xc_sha2_sigma_mcu;

  logic        g_clk = 1'b0;
  logic        g_resetn = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [2:0]  in_op = '0;
  logic [63:0] in_rs1 = '0;
  logic [4:0]  in_rd = '0;

  logic        a_in_ready, a_out_valid, a_out_trap;
  logic [31:0] a_out_result;
  logic [4:0]  a_out_rd;
  logic        b_in_ready, b_out_valid, b_out_trap;
  logic [63:0] b_out_result;
  logic [4:0]  b_out_rd;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 g_clk = ~g_clk;

  xc_sha2_sigma_mcu #(.XLEN(32), .SERIAL(1)) u_dut_a (
    .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_op(in_op),
    .in_rs1(in_rs1[31:0]), .in_rd(in_rd),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_result(a_out_result),
    .out_rd(a_out_rd), .out_trap(a_out_trap)
  );

  xc_sha2_sigma_mcu #(.XLEN(64), .SERIAL(0)) u_dut_b (
    .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rd(in_rd),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_result(b_out_result),
    .out_rd(b_out_rd), .out_trap(b_out_trap)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x} >> n;
    return d[63:0];
  endfunction

  // Reference: SHA-2 sigma/Sum straight from the FIPS 180-4 definitions.
  function automatic logic [63:0] ref_sigma(input int xlen, input logic [2:0] op,
                                            input logic [63:0] rs1, input logic [4:0] rd,
                                            output logic trap);
    int a0, a1, a2;
    logic third_is_shift;
    logic [31:0] y32;
    logic [63:0] y;
    trap = (op >= 3'd4) && (xlen == 32);
    if (trap || rd == 5'd0) return 64'd0;
    case (op)
      3'd0: begin a0 = 7;  a1 = 18; a2 = 3;  end
      3'd1: begin a0 = 17; a1 = 19; a2 = 10; end
      3'd2: begin a0 = 2;  a1 = 13; a2 = 22; end
      3'd3: begin a0 = 6;  a1 = 11; a2 = 25; end
      3'd4: begin a0 = 1;  a1 = 8;  a2 = 7;  end
      3'd5: begin a0 = 19; a1 = 61; a2 = 6;  end
      3'd6: begin a0 = 28; a1 = 34; a2 = 39; end
      default: begin a0 = 14; a1 = 18; a2 = 41; end
    endcase
    third_is_shift = (op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd5);
    if (op < 3'd4) begin
      y32 = ror32(rs1[31:0], a0) ^ ror32(rs1[31:0], a1)
          ^ (third_is_shift ? (rs1[31:0] >> a2) : ror32(rs1[31:0], a2));
      y = (xlen == 32) ? {32'd0, y32} : 64'($signed(y32));
    end else begin
      y = ror64(rs1, a0) ^ ror64(rs1, a1)
        ^ (third_is_shift ? (rs1 >> a2) : ror64(rs1, a2));
    end
    return y;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [63:0] rs1, input logic [4:0] rd);
    @(negedge g_clk);
    check_eq("in_ready_idle", {a_in_ready, b_in_ready}, 2'b11);
    in_valid = 1'b1; in_op = op; in_rs1 = rs1; in_rd = rd;
    @(posedge g_clk);
    #1;
    in_valid = 1'b0;
    in_op = 3'($urandom);
    in_rs1 = {$urandom, $urandom};
    in_rd = 5'($urandom);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [63:0] rs1, input logic [4:0] rd);
    logic [63:0] ea, eb;
    logic ta, tb;
    int la, lb;
    la = 0; lb = 0;
    ea = ref_sigma(32, op, rs1, rd, ta);
    eb = ref_sigma(64, op, rs1, rd, tb);
    issue(op, rs1, rd);
    for (int c = 1; c <= 8; c++) begin
      @(negedge g_clk);
      if (a_out_valid && la == 0) begin
        la = c;
        check_eq("a_result", {32'd0, a_out_result}, ea);
        check_eq("a_rd", a_out_rd, rd);
        check_eq("a_trap", a_out_trap, ta);
      end
      if (b_out_valid && lb == 0) begin
        lb = c;
        check_eq("b_result", b_out_result, eb);
        check_eq("b_rd", b_out_rd, rd);
        check_eq("b_trap", b_out_trap, tb);
      end
    end
    check_eq("a_latency", la, ta ? 1 : 4);
    check_eq("b_latency", lb, 1);
  endtask

  task automatic backpressure(input logic [2:0] op, input logic [63:0] rs1, input logic [4:0] rd);
    logic [63:0] ea, eb;
    logic ta, tb;
    int w;
    ea = ref_sigma(32, op, rs1, rd, ta);
    eb = ref_sigma(64, op, rs1, rd, tb);
    out_ready = 1'b0;
    issue(op, rs1, rd);
    w = 0;
    while (!a_out_valid && w < 10) begin
      @(negedge g_clk);
      w++;
    end
    check_eq("bp_wait", a_out_valid, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge g_clk);
      check_eq("bp_flags", {a_out_valid, b_out_valid, a_in_ready, b_in_ready}, 4'b1100);
      check_eq("bp_a_result", {32'd0, a_out_result}, ea);
      check_eq("bp_b_result", b_out_result, eb);
      check_eq("bp_rd", {a_out_rd, b_out_rd}, {rd, rd});
    end
    out_ready = 1'b1;
    @(negedge g_clk);
    check_eq("bp_release", {a_in_ready, b_in_ready, a_out_valid, b_out_valid}, 4'b1100);
  endtask

  initial begin
    int seen;
    repeat (3) @(negedge g_clk);
    check_eq("rst_a", {a_in_ready, a_out_valid, a_out_trap, a_out_rd, a_out_result},
             {3'b100, 5'd0, 32'd0});
    check_eq("rst_b_result", b_out_result, 64'd0);
    g_resetn = 1'b1;

    run_op(3'd1, 64'h1, 5'd5);
    run_op(3'd0, 64'h8000_0000, 5'd9);
    run_op(3'd2, 64'h1, 5'd1);
    run_op(3'd3, 64'h1, 5'd2);
    run_op(3'd0, 64'h40, 5'd4);
    run_op(3'd4, 64'h1, 5'd3);
    run_op(3'd1, 64'h1, 5'd0);
    run_op(3'd5, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31);
    for (int i = 0; i < 30; i++) begin
      logic [4:0] rd;
      rd = (i % 7 == 0) ? 5'd0 : 5'($urandom);
      run_op(3'($urandom), {$urandom, $urandom}, rd);
    end

    backpressure(3'd6, {$urandom, $urandom}, 5'd12);

    // Flush while the serial unit is in T1.
    issue(3'd1, {$urandom, $urandom}, 5'd7);
    @(posedge g_clk);
    #1 flush = 1'b1;
    @(posedge g_clk);
    #1 flush = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge g_clk);
      if (a_out_valid) seen++;
    end
    check_eq("flush_no_valid", seen, 0);

    // A request presented together with flush is dropped.
    @(negedge g_clk);
    flush = 1'b1; in_valid = 1'b1; in_op = 3'd3; in_rs1 = 64'h1; in_rd = 5'd8;
    @(posedge g_clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge g_clk);
      if (a_out_valid || b_out_valid) seen++;
    end
    check_eq("flush_req_dropped", seen, 0);

    // Reset in T2 of a new op.
    issue(3'd2, {$urandom, $urandom}, 5'd10);
    @(posedge g_clk);
    @(posedge g_clk);
    #1 g_resetn = 1'b0;
    @(negedge g_clk);
    check_eq("midrst_a", {a_in_ready, a_out_valid, a_out_trap, a_out_rd, a_out_result},
             {3'b100, 5'd0, 32'd0});
    check_eq("midrst_b", {b_out_valid, b_out_rd, b_out_result}, {1'b0, 5'd0, 64'd0});
    @(negedge g_clk);
    g_resetn = 1'b1;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge g_clk);
      if (a_out_valid || b_out_valid) seen++;
    end
    check_eq("midrst_no_valid", seen, 0);
    run_op(3'd3, 64'h1, 5'd11);
    run_op(3'd7, {$urandom, $urandom}, 5'd13);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
